// File: rtl/vector_element_sequencer_pkg.sv
// Shared vector types for the element sequencer: widths, element-width encoding
// and sequencer states.
package vector_element_sequencer_pkg;

  localparam int unsigned VLEN      = 128;
  localparam int unsigned NUM_LANES = 2;
  localparam int unsigned EIDX_W    = 8;
  localparam int unsigned OFF_W     = 3;

  typedef enum logic [1:0] {
    SEW8  = 2'd0,
    SEW16 = 2'd1,
    SEW32 = 2'd2
  } sew_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Widening beyond 32 bits, or an unused SEW code, cannot be sequenced.
  function automatic logic width_illegal(sew_t s, logic vd_w, logic vs2_w);
    return ((s == SEW32) && (vd_w || vs2_w)) || (2'(s) == 2'd3);
  endfunction

endpackage

// File: rtl/vector_offset_calc.sv
// Register offset within an LMUL group for one operand: eidx / EPR, where EPR is
// halved for a widened operand. EPR is a power of two, so this is a right shift.
module vector_offset_calc
  import vector_element_sequencer_pkg::*;
#(
  parameter int unsigned VLEN = vector_element_sequencer_pkg::VLEN
) (
  input  logic [EIDX_W-1:0] eidx_i,
  input  sew_t              sew_i,
  input  logic              widen_i,
  output logic [OFF_W-1:0]  offset_o
);

  localparam int unsigned EPR8_LOG2 = $clog2(VLEN / 8);

  logic [2:0] shamt_c;

  assign shamt_c  = 3'(EPR8_LOG2) - 3'(sew_i) - 3'(widen_i);
  assign offset_o = OFF_W'(eidx_i >> shamt_c);

endmodule

// File: rtl/vector_element_sequencer.sv
// Walks the element indices of one vector instruction, NUM_LANES elements per
// cycle, reporting lane validity and per-operand register offsets.
module vector_element_sequencer #(
  parameter int unsigned VLEN      = vector_element_sequencer_pkg::VLEN,
  parameter int unsigned NUM_LANES = vector_element_sequencer_pkg::NUM_LANES
) (
  input  logic                                             CLK,
  input  logic                                             nRST,
  input  logic                                             start,
  output logic                                             ready,
  input  logic [vector_element_sequencer_pkg::EIDX_W-1:0]  vl,
  input  logic [vector_element_sequencer_pkg::EIDX_W-1:0]  vstart,
  input  vector_element_sequencer_pkg::sew_t               sew,
  input  logic                                             vd_widen,
  input  logic                                             vs2_widen,
  input  logic                                             stall,
  input  logic                                             flush,
  output logic                                             busy,
  output logic [vector_element_sequencer_pkg::EIDX_W-1:0]  eidx,
  output logic [NUM_LANES-1:0]                             lane_valid,
  output logic [vector_element_sequencer_pkg::OFF_W-1:0]   vs_offset,
  output logic [vector_element_sequencer_pkg::OFF_W-1:0]   vs2_offset,
  output logic [vector_element_sequencer_pkg::OFF_W-1:0]   vd_offset,
  output logic                                             last,
  output logic                                             done,
  output logic                                             illegal
);
  import vector_element_sequencer_pkg::*;

  localparam int unsigned CMP_W = EIDX_W + 1;

  seq_state_t        state_q, state_d;
  logic [EIDX_W-1:0] eidx_q, eidx_d;
  logic [EIDX_W-1:0] vl_q, vl_d;
  sew_t              sew_q, sew_d;
  logic              vd_widen_q, vd_widen_d;
  logic              vs2_widen_q, vs2_widen_d;
  logic              illegal_q, illegal_d;
  logic              last_c;
  logic [OFF_W-1:0]  vs_off_c, vs2_off_c, vd_off_c;

  // Extra bit keeps the end-of-vector compare exact at eidx + NUM_LANES.
  assign last_c = (CMP_W'(eidx_q) + CMP_W'(NUM_LANES)) >= CMP_W'(vl_q);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= IDLE;
      eidx_q      <= '0;
      vl_q        <= '0;
      sew_q       <= SEW8;
      vd_widen_q  <= 1'b0;
      vs2_widen_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      eidx_q      <= eidx_d;
      vl_q        <= vl_d;
      sew_q       <= sew_d;
      vd_widen_q  <= vd_widen_d;
      vs2_widen_q <= vs2_widen_d;
      illegal_q   <= illegal_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    eidx_d      = eidx_q;
    vl_d        = vl_q;
    sew_d       = sew_q;
    vd_widen_d  = vd_widen_q;
    vs2_widen_d = vs2_widen_q;
    illegal_d   = illegal_q;
    if (flush) begin
      state_d   = IDLE;
      illegal_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            vl_d        = vl;
            eidx_d      = vstart;
            sew_d       = sew;
            vd_widen_d  = vd_widen;
            vs2_widen_d = vs2_widen;
            illegal_d   = width_illegal(sew, vd_widen, vs2_widen);
            if (illegal_d || (vl == '0) || (vstart >= vl)) begin
              state_d = DONE;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (!stall) begin
            eidx_d = eidx_q + EIDX_W'(NUM_LANES);
            if (last_c) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          state_d   = IDLE;
          illegal_d = 1'b0;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  vector_offset_calc #(.VLEN(VLEN)) u_vs_off (
    .eidx_i  (eidx_q),
    .sew_i   (sew_q),
    .widen_i (1'b0),
    .offset_o(vs_off_c)
  );

  vector_offset_calc #(.VLEN(VLEN)) u_vs2_off (
    .eidx_i  (eidx_q),
    .sew_i   (sew_q),
    .widen_i (vs2_widen_q),
    .offset_o(vs2_off_c)
  );

  vector_offset_calc #(.VLEN(VLEN)) u_vd_off (
    .eidx_i  (eidx_q),
    .sew_i   (sew_q),
    .widen_i (vd_widen_q),
    .offset_o(vd_off_c)
  );

  // Group outputs are only meaningful while running; elsewhere they read zero.
  always_comb begin
    ready      = (state_q == IDLE);
    busy       = (state_q == RUN) || (state_q == DONE);
    done       = (state_q == DONE);
    illegal    = (state_q == DONE) && illegal_q;
    eidx       = eidx_q;
    last       = 1'b0;
    lane_valid = '0;
    vs_offset  = '0;
    vs2_offset = '0;
    vd_offset  = '0;
    if (state_q == RUN) begin
      last       = last_c;
      vs_offset  = vs_off_c;
      vs2_offset = vs2_off_c;
      vd_offset  = vd_off_c;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        lane_valid[i] = (CMP_W'(eidx_q) + CMP_W'(i)) < CMP_W'(vl_q);
      end
    end
  end

endmodule

// File: tb/tb_vector_element_sequencer.sv
// Randomized and directed checks of vector_element_sequencer against an
// instruction-level reference that lists the expected element groups.
module tb_vector_element_sequencer;
  import vector_element_sequencer_pkg::*;

  localparam int NL = NUM_LANES;
  localparam int VL = VLEN;

  logic                  CLK = 1'b0;
  logic                  nRST, start, ready, vd_widen, vs2_widen, stall, flush;
  logic [EIDX_W-1:0]     vl, vstart, eidx;
  sew_t                  sew;
  logic                  busy, last, done, illegal;
  logic [NUM_LANES-1:0]  lane_valid;
  logic [OFF_W-1:0]      vs_offset, vs2_offset, vd_offset;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 CLK = ~CLK;

  vector_element_sequencer dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .start     (start),
    .ready     (ready),
    .vl        (vl),
    .vstart    (vstart),
    .sew       (sew),
    .vd_widen  (vd_widen),
    .vs2_widen (vs2_widen),
    .stall     (stall),
    .flush     (flush),
    .busy      (busy),
    .eidx      (eidx),
    .lane_valid(lane_valid),
    .vs_offset (vs_offset),
    .vs2_offset(vs2_offset),
    .vd_offset (vd_offset),
    .last      (last),
    .done      (done),
    .illegal   (illegal)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Elements per register for a given SEW code, halved for a widened operand.
  function automatic int epr_of(input int s, input bit w);
    int e;
    e = VL / (8 << s);
    return w ? e / 2 : e;
  endfunction

  function automatic int off_of(input int e, input int s, input bit w);
    return (e / epr_of(s, w)) % 8;
  endfunction

  function automatic logic [31:0] mask_of(input int e, input int v);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < NL; i++) if (e + i < v) m[i] = 1'b1;
    return m;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, ready, 1);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_lv"}, lane_valid, 0);
    check_eq({tag, "_offs"}, {vs_offset, vs2_offset, vd_offset}, 0);
    check_eq({tag, "_last"}, last, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_illegal"}, illegal, 0);
    check_eq({tag, "_eidx"}, eidx, 0);
  endtask

  // One instruction from accept to return to idle; called and returning on a negedge.
  task automatic do_instr(input int v, input int vs, input int s, input bit vdw, input bit vs2w,
                          input bit rnd_stall, input int st_eidx, input int st_len,
                          input int flush_eidx, input bit rnd_start);
    int e, stall_cnt, budget;
    bit st, bad, empty;
    check_eq("ready_pre", ready, 1);
    start = 1'b1; vl = 8'(v); vstart = 8'(vs); sew = sew_t'(s);
    vd_widen = vdw; vs2_widen = vs2w;
    @(posedge CLK); @(negedge CLK);
    start = 1'b0;
    bad   = (s == 2) && (vdw || vs2w);
    empty = (v == 0) || (vs >= v);
    if (bad || empty) begin
      check_eq("nogrp_done", done, 1);
      check_eq("nogrp_illegal", illegal, bad);
      check_eq("nogrp_lv", lane_valid, 0);
      check_eq("nogrp_ready", ready, 0);
      @(negedge CLK);
      check_eq("nogrp_done_once", done, 0);
      check_eq("nogrp_ready_after", ready, 1);
      return;
    end
    e = vs; stall_cnt = 0; budget = 0;
    forever begin
      check_eq("run_busy", busy, 1);
      check_eq("run_eidx", eidx, e);
      check_eq("run_lv", lane_valid, mask_of(e, v));
      check_eq("run_vs_off", vs_offset, off_of(e, s, 1'b0));
      check_eq("run_vs2_off", vs2_offset, off_of(e, s, vs2w));
      check_eq("run_vd_off", vd_offset, off_of(e, s, vdw));
      check_eq("run_last", last, (e + NL >= v));
      check_eq("run_done", done, 0);
      if (e == flush_eidx) begin
        flush = 1'b1; start = 1'b1; stall = 1'b1;
        @(posedge CLK); @(negedge CLK);
        flush = 1'b0; start = 1'b0; stall = 1'b0;
        check_eq("flush_ready", ready, 1);
        check_eq("flush_busy", busy, 0);
        check_eq("flush_done", done, 0);
        @(negedge CLK);
        check_eq("flush_no_done", done, 0);
        return;
      end
      st = 1'b0;
      if (e == st_eidx && stall_cnt < st_len) begin
        st = 1'b1;
        stall_cnt++;
      end else if (rnd_stall && $urandom_range(0, 3) == 0) begin
        st = 1'b1;
      end
      stall = st;
      if (rnd_start) begin
        start = 1'($urandom_range(0, 1));
        vl = 8'($urandom); vstart = 8'($urandom);
        sew = sew_t'($urandom_range(0, 2));
        vd_widen = 1'($urandom); vs2_widen = 1'($urandom);
      end
      @(posedge CLK); @(negedge CLK);
      start = 1'b0; stall = 1'b0;
      if (!st) begin
        if (e + NL >= v) break;
        e += NL;
      end
      budget++;
      if (budget > 1000) begin
        n_cmp++; n_err++;
        $display("FAIL run_budget: got no completion after %0d cycles, expected done", budget);
        return;
      end
    end
    check_eq("end_done", done, 1);
    check_eq("end_illegal", illegal, 0);
    check_eq("end_lv", lane_valid, 0);
    check_eq("end_busy", busy, 1);
    @(negedge CLK);
    check_eq("end_done_once", done, 0);
    check_eq("end_ready", ready, 1);
    check_eq("end_busy_off", busy, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int s, v, vs, maxv, fe;
    bit vdw, vs2w;
    nRST = 1'b0; start = 1'b0; stall = 1'b0; flush = 1'b0;
    vl = '0; vstart = '0; sew = SEW8; vd_widen = 1'b0; vs2_widen = 1'b0;
    repeat (2) @(negedge CLK);
    check_reset_outputs("rst");
    nRST = 1'b1;
    @(negedge CLK);

    do_instr(8, 0, 0, 0, 0, 0, -1, 0, -1, 0);
    do_instr(7, 0, 1, 1, 0, 0, -1, 0, -1, 0);
    do_instr(7, 0, 2, 0, 0, 0, -1, 0, -1, 0);
    do_instr(20, 0, 1, 0, 0, 0, 4, 3, -1, 0);
    do_instr(0, 0, 0, 0, 0, 0, -1, 0, -1, 0);
    do_instr(10, 10, 0, 0, 0, 0, -1, 0, -1, 0);
    do_instr(16, 0, 2, 0, 1, 0, -1, 0, -1, 0);
    do_instr(8, 0, 2, 1, 0, 0, -1, 0, -1, 0);
    do_instr(16, 0, 0, 0, 0, 0, -1, 0, 4, 0);
    do_instr(128, 1, 0, 0, 0, 0, -1, 0, -1, 0);

    // flush wins over start in idle
    start = 1'b1; flush = 1'b1; vl = 8'd8; vstart = 8'd0; sew = SEW8;
    @(posedge CLK); @(negedge CLK);
    start = 1'b0; flush = 1'b0;
    check_eq("idle_flush_ready", ready, 1);
    check_eq("idle_flush_busy", busy, 0);

    // reset in the middle of a run
    start = 1'b1; vl = 8'd16; vstart = 8'd0; sew = SEW8; vd_widen = 1'b0; vs2_widen = 1'b0;
    @(posedge CLK); @(negedge CLK);
    start = 1'b0;
    repeat (2) @(negedge CLK);
    check_eq("midrst_busy_pre", busy, 1);
    nRST = 1'b0;
    @(negedge CLK);
    check_reset_outputs("midrst");
    nRST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check_eq("midrst_no_done", done, 0);
      check_eq("midrst_ready", ready, 1);
    end

    for (int n = 0; n < 150; n++) begin
      s    = $urandom_range(0, 2);
      vdw  = ($urandom_range(0, 3) == 0);
      vs2w = ($urandom_range(0, 3) == 0);
      maxv = 8 * epr_of(s, vdw || vs2w);
      if (maxv > 128) maxv = 128;
      v  = $urandom_range(0, maxv);
      vs = ($urandom_range(0, 3) == 0) ? $urandom_range(0, v + 3) : $urandom_range(0, 3);
      fe = ($urandom_range(0, 7) == 0) ? vs + NL * $urandom_range(0, 8) : -1;
      do_instr(v, vs, s, vdw, vs2w, 1, -1, 0, fe, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
